// File: rtl/ktu_sched_pkg.sv
// Shared types and sizes for the kernel-transform batch scheduler.
// Kernel and tile geometry plus the scheduler state encoding.
package ktu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int KDIM         = 3;
  localparam int TDIM         = 6;
  localparam int KERNEL_ELEMS = 9;
  localparam int TILE_ELEMS   = 36;
  localparam int STEP_W       = 6;

endpackage

// File: rtl/ktu_batch_scheduler.sv
// Batch sequencer: loads 3x3 kernels, kicks the KTU,
// and streams each 6x6 transformed tile to the destination buffer.
module ktu_batch_scheduler
  import ktu_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  kernel_count,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  src_rd_en,
  output logic [ADDR_WIDTH-1:0] src_rd_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  ktu_start,
  output logic [DATA_WIDTH-1:0] ktu_kernel_in [0:KDIM-1][0:KDIM-1],
  input  logic [DATA_WIDTH-1:0] ktu_kernel_out [0:TDIM-1][0:TDIM-1],
  input  logic                  ktu_transform_done,
  output logic                  dst_wr_en,
  output logic [ADDR_WIDTH-1:0] dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data
);

  state_t                state, state_n;
  logic [STEP_W-1:0]     cnt, cnt_n;
  logic [CNT_WIDTH-1:0]  count, count_n;
  logic [CNT_WIDTH-1:0]  idx, idx_n;
  logic [ADDR_WIDTH-1:0] src_ptr, src_ptr_n;
  logic [ADDR_WIDTH-1:0] dst_ptr, dst_ptr_n;

  logic                  busy_n, done_n, kick_n;
  logic                  rd_en_n, wr_en_n;
  logic [ADDR_WIDTH-1:0] rd_addr_n, wr_addr_n;

  logic [DATA_WIDTH-1:0] shadow [0:TILE_ELEMS-1];

  // Next state, step counter, pointers and next registered outputs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + STEP_W'(1);
    count_n   = count;
    idx_n     = idx;
    src_ptr_n = src_ptr;
    dst_ptr_n = dst_ptr;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start) begin
          count_n   = kernel_count;
          idx_n     = '0;
          src_ptr_n = src_base;
          dst_ptr_n = dst_base;
          state_n   = (kernel_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt == STEP_W'(KERNEL_ELEMS)) begin
          state_n = S_KICK;
          cnt_n   = '0;
        end
      end
      S_KICK: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
      S_WAIT: begin
        cnt_n = '0;
        if (ktu_transform_done) state_n = S_STORE;
      end
      S_STORE: begin
        if (cnt == STEP_W'(TILE_ELEMS - 1)) begin
          state_n = S_NEXT;
          cnt_n   = '0;
        end
      end
      S_NEXT: begin
        cnt_n     = '0;
        src_ptr_n = src_ptr + ADDR_WIDTH'(KERNEL_ELEMS);
        dst_ptr_n = dst_ptr + ADDR_WIDTH'(TILE_ELEMS);
        idx_n     = idx + CNT_WIDTH'(1);
        state_n   = (idx_n == count) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
    kick_n = (state_n == S_KICK);

    // Read i is issued in LOAD step i; step 9 only drains the last read.
    rd_en_n   = (state_n == S_LOAD) &&
                (cnt_n < STEP_W'(KERNEL_ELEMS));
    rd_addr_n = src_rd_addr;
    if (rd_en_n) begin
      rd_addr_n = (state == S_LOAD) ?
                  src_rd_addr + ADDR_WIDTH'(1) : src_ptr_n;
    end

    wr_en_n   = (state_n == S_STORE);
    wr_addr_n = dst_wr_addr;
    if (wr_en_n) begin
      wr_addr_n = (state == S_STORE) ?
                  dst_wr_addr + ADDR_WIDTH'(1) : dst_ptr;
    end
  end

  // State, counters, pointers and control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      count       <= '0;
      idx         <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ktu_start   <= 1'b0;
      src_rd_en   <= 1'b0;
      src_rd_addr <= '0;
      dst_wr_en   <= 1'b0;
      dst_wr_addr <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      count       <= count_n;
      idx         <= idx_n;
      src_ptr     <= src_ptr_n;
      dst_ptr     <= dst_ptr_n;
      busy        <= busy_n;
      done        <= done_n;
      ktu_start   <= kick_n;
      src_rd_en   <= rd_en_n;
      src_rd_addr <= rd_addr_n;
      dst_wr_en   <= wr_en_n;
      dst_wr_addr <= wr_addr_n;
    end
  end

  // Kernel capture in LOAD, tile latch on KTU done, shift-out in STORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KDIM; r++)
        for (int c = 0; c < KDIM; c++)
          ktu_kernel_in[r][c] <= '0;
      for (int k = 0; k < TILE_ELEMS; k++)
        shadow[k] <= '0;
      dst_wr_data <= '0;
    end else begin
      if (state == S_LOAD) begin
        for (int r = 0; r < KDIM; r++)
          for (int c = 0; c < KDIM; c++)
            if (cnt == STEP_W'(KDIM * r + c + 1))
              ktu_kernel_in[r][c] <= src_rd_data;
      end
      if (state == S_WAIT && ktu_transform_done) begin
        for (int r = 0; r < TDIM; r++)
          for (int c = 0; c < TDIM; c++)
            shadow[TDIM * r + c] <= ktu_kernel_out[r][c];
        dst_wr_data <= ktu_kernel_out[0][0];
      end else if (state == S_STORE) begin
        for (int k = 0; k < TILE_ELEMS - 1; k++)
          shadow[k] <= shadow[k + 1];
        if (cnt != STEP_W'(TILE_ELEMS - 1))
          dst_wr_data <= shadow[1];
      end
    end
  end

endmodule

// File: tb/tb_ktu_batch_scheduler.sv
// Bench for ktu_batch_scheduler: BRAM and KTU stubs, event log,
// table-driven and random batches checked against a timing model.
module tb_ktu_batch_scheduler;
  import ktu_sched_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] kernel_count = '0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic          busy, done, src_rd_en, ktu_start, dst_wr_en;
  logic [AW-1:0] src_rd_addr, dst_wr_addr;
  logic [DW-1:0] src_rd_data = '0;
  logic [DW-1:0] dst_wr_data;
  logic [DW-1:0] ktu_kernel_in [0:2][0:2];
  logic [DW-1:0] kout [0:5][0:5];
  logic          ktu_transform_done;
  logic          stub_done = 1'b0;
  logic          spur = 1'b0;

  assign ktu_transform_done = stub_done | spur;

  ktu_batch_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .kernel_count      (kernel_count),
    .src_base          (src_base),
    .dst_base          (dst_base),
    .busy              (busy),
    .done              (done),
    .src_rd_en         (src_rd_en),
    .src_rd_addr       (src_rd_addr),
    .src_rd_data       (src_rd_data),
    .ktu_start         (ktu_start),
    .ktu_kernel_in     (ktu_kernel_in),
    .ktu_kernel_out    (kout),
    .ktu_transform_done(ktu_transform_done),
    .dst_wr_en         (dst_wr_en),
    .dst_wr_addr       (dst_wr_addr),
    .dst_wr_data       (dst_wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int c0 = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  bit mon_on = 1'b0;
  int lat = 5;
  bit fixed_mode = 1'b1;
  logic [DW-1:0] src_mem [0:4095];

  int rd_t[$], rd_a[$], kk_t[$], kin_q[$];
  int wr_t[$], wr_a[$], wr_d[$], dn_t[$];

  function automatic logic [DW-1:0] kfun(logic [DW-1:0] x, int j);
    return DW'(32'(x) * 3 + j);
  endfunction

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Cycle counter and source BRAM with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];
    if (dst_wr_en) wr_cnt <= wr_cnt + 1;
  end

  // Event log sampled mid-cycle, cycle 0 being the start cycle.
  always @(negedge clk) begin
    int mt;
    mt = cyc - c0;
    if (mon_on) begin
      if (src_rd_en) begin
        rd_t.push_back(mt);
        rd_a.push_back(int'(src_rd_addr));
      end
      if (ktu_start) begin
        kk_t.push_back(mt);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            kin_q.push_back(int'(ktu_kernel_in[r][c]));
      end
      if (dst_wr_en) begin
        wr_t.push_back(mt);
        wr_a.push_back(int'(dst_wr_addr));
        wr_d.push_back(int'(dst_wr_data));
      end
      if (done) dn_t.push_back(mt);
      if (busy) busy_cnt++;
    end
  end

  // KTU stub: done arrives L cycles after the start pulse cycle.
  always begin
    @(negedge clk);
    if (ktu_start) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          kout[r][c] = fixed_mode ? DW'(100 + 6 * r + c) :
            kfun(ktu_kernel_in[((6*r+c)%9)/3][((6*r+c)%9)%3], 6*r+c);
      repeat (lat) @(posedge clk);
      #1 stub_done = 1'b1;
      @(posedge clk);
      #1 stub_done = 1'b0;
    end
  end

  task automatic check_reset(string nm);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_done"}, int'(done), 0);
    check({nm, "_rd_en"}, int'(src_rd_en), 0);
    check({nm, "_kick"}, int'(ktu_start), 0);
    check({nm, "_wr_en"}, int'(dst_wr_en), 0);
    check({nm, "_rd_addr"}, int'(src_rd_addr), 0);
    check({nm, "_wr_addr"}, int'(dst_wr_addr), 0);
    check({nm, "_wr_data"}, int'(dst_wr_data), 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("%s_kin%0d%0d", nm, r, c),
              int'(ktu_kernel_in[r][c]), 0);
  endtask

  task automatic run_batch(int n, int src, int dst, int l, bit fx,
                           bit inj, int abort_at, int exp_done,
                           string nm);
    int t, p, w0, e;
    bit got;
    lat = l;
    fixed_mode = fx;
    rd_t.delete(); rd_a.delete(); kk_t.delete(); kin_q.delete();
    wr_t.delete(); wr_a.delete(); wr_d.delete(); dn_t.delete();
    busy_cnt = 0;
    p = 48 + l;
    @(negedge clk);
    kernel_count = CW'(n);
    src_base = AW'(src);
    dst_base = AW'(dst);
    start = 1'b1;
    c0 = cyc;
    mon_on = 1'b1;
    got = 1'b0;
    for (int i = 0; i < exp_done + 20 && !got; i++) begin
      @(negedge clk);
      t = cyc - c0;
      start = 1'b0;
      if (inj) begin
        spur = (t == 5);
        if (t == 13) begin
          start = 1'b1;
          kernel_count = CW'(9);
          src_base = AW'(7);
          dst_base = AW'(1);
        end
      end
      if (abort_at != 0 && t == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset({nm, "_rst"});
        check({nm, "_wr_seen"}, wr_t.size(), abort_at - (12 + l) + 1);
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        check({nm, "_no_wr"}, wr_cnt - w0, 0);
        check({nm, "_idle"}, int'(busy), 0);
        rst_n = 1'b1;
        mon_on = 1'b0;
        return;
      end
      if (dn_t.size() > 0) got = 1'b1;
    end
    if (!got) check({nm, "_done_timeout"}, 0, 1);
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    spur = 1'b0;

    check({nm, "_done_n"}, dn_t.size(), 1);
    if (dn_t.size() > 0) check({nm, "_done_cyc"}, dn_t[0], exp_done);
    check({nm, "_busy_cyc"}, busy_cnt, exp_done);
    check({nm, "_rd_n"}, rd_t.size(), 9 * n);
    for (int x = 0; x < rd_t.size() && x < 9 * n; x++) begin
      check($sformatf("%s_rd%0d_cyc", nm, x), rd_t[x],
            (x / 9) * p + 1 + x % 9);
      check($sformatf("%s_rd%0d_addr", nm, x), rd_a[x],
            (src + x) % 4096);
    end
    check({nm, "_kick_n"}, kk_t.size(), n);
    for (int k = 0; k < kk_t.size() && k < n; k++) begin
      check($sformatf("%s_kick%0d_cyc", nm, k), kk_t[k], k * p + 11);
      for (int i = 0; i < 9; i++)
        check($sformatf("%s_kin%0d_%0d", nm, k, i), kin_q[9*k+i],
              int'(src_mem[(src + 9*k + i) % 4096]));
    end
    check({nm, "_wr_n"}, wr_t.size(), 36 * n);
    for (int x = 0; x < wr_t.size() && x < 36 * n; x++) begin
      e = fx ? 100 + x % 36 :
          int'(kfun(src_mem[(src + 9*(x/36) + (x%36)%9) % 4096], x % 36));
      check($sformatf("%s_wr%0d_cyc", nm, x), wr_t[x],
            (x / 36) * p + 12 + l + x % 36);
      check($sformatf("%s_wr%0d_addr", nm, x), wr_a[x],
            (dst + x) % 4096);
      check($sformatf("%s_wr%0d_data", nm, x), wr_d[x], e);
    end
  endtask

  typedef struct packed {
    int n;
    int src;
    int dst;
    int lat;
    bit fx;
    bit inj;
    int done_cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n, l;
    vecs[0] = '{1, 0,    200,  5, 1'b1, 1'b0, 54};
    vecs[1] = '{3, 0,    64,   5, 1'b1, 1'b0, 160};
    vecs[2] = '{1, 4090, 4080, 5, 1'b0, 1'b0, 54};
    vecs[3] = '{0, 10,   10,   5, 1'b0, 1'b0, 1};
    vecs[4] = '{2, 300,  900,  5, 1'b0, 1'b1, 107};
    vecs[5] = '{2, 17,   33,   1, 1'b0, 1'b0, 99};
    for (int a = 0; a < 4096; a++) src_mem[a] = DW'(a + 1);

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_batch(vecs[i].n, vecs[i].src, vecs[i].dst, vecs[i].lat,
                vecs[i].fx, vecs[i].inj, 0, vecs[i].done_cyc,
                $sformatf("v%0d", i));

    run_batch(1, 40, 400, 5, 1'b0, 1'b0, 27, 54, "abort");
    run_batch(2, 40, 400, 5, 1'b0, 1'b0, 0, 107, "after_abort");

    for (int a = 0; a < 4096; a++) src_mem[a] = DW'($urandom);
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(1, 3));
      l = int'($urandom_range(1, 12));
      run_batch(n, int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 4095)), l, 1'b0, 1'b0, 0,
                n * (48 + l) + 1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ktu_batch_scheduler.md
# ktu_batch_scheduler

Sequences a batch of 3×3 kernels through the external `kernel_transform_unit` (Winograd kernel transform, 3×3 → 6×6, 16-bit).
- Per kernel: read 9 words from a source kernel buffer, pulse the transform, latch the 6×6 result, write 36 words to a destination buffer.
- Sits between the kernel BRAM and the transformed-kernel BRAM, under the convolution top-level controller.

## Interface
- `DATA_WIDTH`, 16, element width (must match the KTU)
- `ADDR_WIDTH`, 12, word address width of both buffers
- `CNT_WIDTH`, 7, width of the kernel count
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: batch request, sampled in IDLE only
- `kernel_count` in CNT_WIDTH: kernels in batch, sampled with `start`
- `src_base` in ADDR_WIDTH: source address of kernel 0, sampled with `start`
- `dst_base` in ADDR_WIDTH: destination address of kernel 0, sampled with `start`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at batch end
- `src_rd_en` out 1: source read strobe
- `src_rd_addr` out ADDR_WIDTH: source read address
- `src_rd_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `src_rd_en`
- `ktu_start` out 1: one-cycle transform start pulse
- `ktu_kernel_in` out DATA_WIDTH [0:2][0:2]: registered kernel to the KTU
- `ktu_kernel_out` in DATA_WIDTH [0:5][0:5]: KTU result
- `ktu_transform_done` in 1: KTU completion pulse
- `dst_wr_en` out 1: destination write strobe
- `dst_wr_addr` out ADDR_WIDTH: destination write address
- `dst_wr_data` out DATA_WIDTH: destination write data

## Operation
- States: IDLE, LOAD, KICK, WAIT, STORE, NEXT, DONE.
- IDLE:
  - `start` = 1 latches `kernel_count`, `src_base` and `dst_base`.
  - Count 0 → DONE; otherwise → LOAD.
- LOAD, 10 cycles:
  - Cycles 1–9 issue reads with index i = 0..8 at address `src_ptr`+i.
  - Each read's data is captured one cycle later into `ktu_kernel_in[i/3][i%3]`, row-major.
  - → KICK.
- KICK, 1 cycle: `ktu_start` = 1; → WAIT.
- WAIT:
  - Hold until `ktu_transform_done` = 1.
  - On that cycle, latch all 36 `ktu_kernel_out` elements into a shadow register; → STORE.
- STORE, 36 cycles: write shadow element j (row-major, j = 6r+c) to `dst_ptr`+j.
- NEXT, 1 cycle:
  - `src_ptr` += 9, `dst_ptr` += 36, kernel index += 1.
  - Index = count → DONE; otherwise → LOAD.
- DONE, 1 cycle: `done` = 1; → IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- Pointers advance by running adds. No multipliers.
- `ktu_kernel_in` changes only in LOAD, so it is stable from KICK through WAIT.
- `start` outside IDLE is ignored. No queuing.
- `ktu_transform_done` outside WAIT is ignored.
- Reset asserted at any time:
  - Immediately returns to IDLE and clears counters, pointers and `ktu_kernel_in`.
  - Writes already issued are not undone.

## Timing
- Reset values:
  - `busy`, `done`, `src_rd_en`, `ktu_start`, `dst_wr_en` = 0.
  - All address, data and `ktu_kernel_in` outputs = 0.
- All outputs are registered.
- Cycle numbering: `start` accepted at edge 0.
  - LOAD occupies cycles 1–10; reads are issued in cycles 1–9.
  - KICK is cycle 11.
- KTU latency L: `ktu_transform_done` arrives in cycle 11+L, L ≥ 1.
- STORE occupies cycles 12+L to 47+L; NEXT is cycle 48+L.
- Per-kernel period is 48+L cycles. For N kernels, `done` is high in cycle N·(48+L)+1.
- Count 0: `busy` and `done` are both high in cycle 1 only.
- `dst_wr_en`, `dst_wr_addr` and `dst_wr_data` change together, one word per cycle, with no gaps inside STORE.

## Structure
- Package `ktu_sched_pkg` holds:
  - the state enum;
  - `KDIM`=3, `TDIM`=6, `KERNEL_ELEMS`=9, `TILE_ELEMS`=36.
- Single module, no sub-module.
- `kernel_transform_unit` is instantiated beside the scheduler at the top level, not inside it.

## Test plan
- Single kernel, source words 1..9 at `src_base` 0, KTU stub with L=5 returning `kernel_out[r][c]` = 100+6r+c:
  - reads to addresses 0..8;
  - `ktu_kernel_in[r][c]` = 3r+c+1;
  - exactly one `ktu_start` pulse, in cycle 11;
  - writes 100..135 to addresses `dst_base`..`dst_base`+35;
  - `done` in cycle 54.
- N=3, L=5, `dst_base` 64:
  - three `ktu_start` pulses, 53 cycles apart;
  - destination writes span addresses 64..171 contiguously;
  - `done` in cycle 160.
- `src_base` 4090, `dst_base` 4080: reads 4090..4095 then 0..2; writes 4080..4095 then 0..19 (wrap).
- `kernel_count` 0: `busy` and `done` both high in cycle 1 only; no reads, writes or `ktu_start`.
- `start` repulsed during WAIT, plus a spurious `ktu_transform_done` during LOAD: batch is unaffected and exactly N kernels are processed.
- `rst_n` low mid-STORE (write j=10):
  - outputs go to reset values immediately, with no further writes;
  - a fresh `start` after release runs a complete batch from kernel 0.
